// File: rtl/controller_sysid_pkg.sv
// Shared types and constants for the controller system-ID checker.
// The expected ID/timestamp defaults are shared with the sysid slave generator.
package controller_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID = 32'd49153;
  localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1531282209;

  function automatic logic word_mismatch(
    input logic [31:0] got,
    input logic [31:0] want
  );
    return got != want;
  endfunction

endpackage

// File: rtl/controller_sysid_read_port.sv
// Avalon-MM read issue, waitrequest hold and read-latency alignment.
// Optional waitrequest watchdog under SYSID_CHECK_TIMEOUT_EN.
module controller_sysid_read_port
  import controller_sysid_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue,
  input  logic        issue_addr,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic        accept,
  output logic        capture,
  output logic [31:0] capture_data,
  output logic        abort
);

  localparam int LW = $clog2(READ_LATENCY + 2);

  logic [LW-1:0] lat_cnt;

  assign accept       = sysid_read & ~sysid_waitrequest;
  assign capture_data = sysid_readdata;
  assign capture      = (READ_LATENCY == 0) ? accept
                                            : (lat_cnt == LW'(1));

  // Read strobe and address; held while the slave stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sysid_read    <= 1'b0;
      sysid_address <= SYSID_ADDR_ID;
    end else if (abort) begin
      sysid_read <= 1'b0;
    end else if (issue) begin
      sysid_read    <= 1'b1;
      sysid_address <= issue_addr;
    end else if (accept) begin
      sysid_read <= 1'b0;
    end
  end

  // Counts down the pipelined-bridge latency after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (accept) begin
      lat_cnt <= LW'(READ_LATENCY);
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LW'(1);
    end
  end

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_cnt;
  logic          stall;

  assign stall = sysid_read & sysid_waitrequest;
  assign abort = stall & (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  // Consecutive stall-cycle counter for the watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!stall || abort) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort = 1'b0;
`endif

endmodule

// File: rtl/controller_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp, compares, retries.
// Optional waitrequest watchdog: define SYSID_CHECK_TIMEOUT_EN.
module controller_sysid_checker
  import controller_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          RETRY_MAX          = 3,
  parameter int          TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [$clog2(RETRY_MAX+1)-1:0] attempts,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int AW = $clog2(RETRY_MAX + 1);

  state_t      state;
  logic        issue;
  logic        issue_addr;
  logic        accept;
  logic        capture;
  logic        abort;
  logic [31:0] capture_data;
  logic        id_bad;
  logic        ts_bad;
  logic        can_retry;

  assign id_bad    = word_mismatch(id_value, EXPECTED_ID);
  assign ts_bad    = word_mismatch(ts_value, EXPECTED_TIMESTAMP);
  assign can_retry = attempts < AW'(RETRY_MAX);

  controller_sysid_read_port #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clock            (clock),
    .reset            (reset),
    .issue            (issue),
    .issue_addr       (issue_addr),
    .sysid_address    (sysid_address),
    .sysid_read       (sysid_read),
    .sysid_waitrequest(sysid_waitrequest),
    .sysid_readdata   (sysid_readdata),
    .accept           (accept),
    .capture          (capture),
    .capture_data     (capture_data),
    .abort            (abort)
  );

  // Launch a read whenever the FSM enters RD_ID or RD_TS
  always_comb begin
    issue      = 1'b0;
    issue_addr = SYSID_ADDR_ID;
    unique case (state)
      IDLE, DONE: issue = start;
      RD_ID, WAIT_ID: begin
        issue      = capture;
        issue_addr = SYSID_ADDR_TS;
      end
      CHECK: issue = (id_bad || ts_bad) && can_retry;
      default: ;
    endcase
  end

  // Check sequencer with registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      attempts    <= '0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            attempts    <= '0;
            busy        <= 1'b1;
            state       <= RD_ID;
          end
        end
        RD_ID, WAIT_ID: begin
          if (abort) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else if (capture) begin
            id_value <= capture_data;
            state    <= RD_TS;
          end else if (accept) begin
            state <= WAIT_ID;
          end
        end
        RD_TS, WAIT_TS: begin
          if (abort) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else if (capture) begin
            ts_value <= capture_data;
            state    <= CHECK;
          end else if (accept) begin
            state <= WAIT_TS;
          end
        end
        CHECK: begin
          id_mismatch <= id_bad;
          ts_mismatch <= ts_bad;
          if (!id_bad && !ts_bad) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (can_retry) begin
            attempts <= attempts + AW'(1);
            state    <= RD_ID;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sysid_checker.sv
// Testbench for controller_sysid_checker (latency 0 and latency 2 instances).
// Timeout scenario runs only when SYSID_CHECK_TIMEOUT_EN is defined.
module tb_controller_sysid_checker;

  localparam logic [31:0] GID = 32'd49153;
  localparam logic [31:0] GTS = 32'd1531282209;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        bad_first;
    logic        pass;
    logic        idm;
    logic        tsm;
    logic        to;
    logic [1:0]  att;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          cyc;
    int          poke;
    logic [1:0]  poke_att;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic [31:0] s_id = GID;
  logic [31:0] s_ts = GTS;
  logic        s_bad = 1'b0;
  logic        s_stall = 1'b0;
  logic        s_stuck = 1'b0;
  logic        s_clr = 1'b0;
  logic        sel = 1'b0;

  logic        addr0, rd0, wr0, busy0, done0, pass0, idm0, tsm0, to0;
  logic [31:0] rdata0, idv0, tsv0;
  logic [1:0]  att0;
  logic        addr2, rd2, wr2, busy2, done2, pass2, idm2, tsm2, to2;
  logic [31:0] rdata2, idv2, tsv2;
  logic [1:0]  att2;

  logic        m_addr, m_rd, m_wr, m_busy, m_done, m_pass, m_idm, m_tsm, m_to;
  logic [31:0] m_idv, m_tsv;
  logic [1:0]  m_att;

  int cnt0, cnt2, st2;
  logic [31:0] d1, d2;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t vec[4];

  always #5 clk = ~clk;

  controller_sysid_checker #(
    .READ_LATENCY(0), .TIMEOUT_CYCLES(16)
  ) dut0 (
    .clock(clk), .reset(reset), .start(start && !sel),
    .sysid_address(addr0), .sysid_read(rd0),
    .sysid_waitrequest(wr0), .sysid_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0),
    .id_mismatch(idm0), .ts_mismatch(tsm0), .timeout(to0),
    .attempts(att0), .id_value(idv0), .ts_value(tsv0)
  );

  controller_sysid_checker #(
    .READ_LATENCY(2), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clock(clk), .reset(reset), .start(start && sel),
    .sysid_address(addr2), .sysid_read(rd2),
    .sysid_waitrequest(wr2), .sysid_readdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2),
    .id_mismatch(idm2), .ts_mismatch(tsm2), .timeout(to2),
    .attempts(att2), .id_value(idv2), .ts_value(tsv2)
  );

  // Slave for dut0: zero-latency, optional bad timestamp on first read
  assign wr0 = s_stuck;
  always_comb begin
    rdata0 = 32'hDEAD_BEEF;
    if (rd0)
      rdata0 = !addr0 ? s_id : ((s_bad && cnt0 == 0) ? ~s_ts : s_ts);
  end
  always @(posedge clk) begin
    if (s_clr) cnt0 <= 0;
    else if (rd0 && !wr0 && addr0) cnt0 <= cnt0 + 1;
  end

  // Slave for dut2: 5-cycle stall per read, 2-cycle read latency
  assign wr2 = s_stuck || (rd2 && s_stall && st2 < 5);
  assign rdata2 = d2;
  always @(posedge clk) begin
    if (s_clr) begin
      st2 <= 0;
      cnt2 <= 0;
    end else begin
      if (rd2 && wr2) st2 <= st2 + 1;
      else if (rd2) st2 <= 0;
      if (rd2 && !wr2 && addr2) cnt2 <= cnt2 + 1;
    end
    d1 <= (rd2 && !wr2) ? (addr2 ? s_ts : s_id) : 32'hDEAD_BEEF;
    d2 <= d1;
  end

  always_comb begin
    m_addr = sel ? addr2 : addr0;
    m_rd   = sel ? rd2 : rd0;
    m_wr   = sel ? wr2 : wr0;
    m_busy = sel ? busy2 : busy0;
    m_done = sel ? done2 : done0;
    m_pass = sel ? pass2 : pass0;
    m_idm  = sel ? idm2 : idm0;
    m_tsm  = sel ? tsm2 : tsm0;
    m_to   = sel ? to2 : to0;
    m_att  = sel ? att2 : att0;
    m_idv  = sel ? idv2 : idv0;
    m_tsv  = sel ? tsv2 : tsv0;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input exp_t e);
    int n;
    logic prev_stall;
    logic prev_addr;
    exp_t q;
    sb.push_back(e);
    s_id = e.id;
    s_ts = e.ts;
    s_bad = e.bad_first;
    @(negedge clk);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    chk("start_clears_done", {63'd0, m_done}, 64'd0);
    prev_stall = m_rd && m_wr;
    prev_addr = m_addr;
    while (!m_done && n < 300) begin
      if (n == e.poke) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n++;
      if (prev_stall && !m_done)
        chk("stall_hold", {62'd0, m_rd, m_addr}, {62'd0, 1'b1, prev_addr});
      prev_stall = m_rd && m_wr;
      prev_addr = m_addr;
      if (e.poke != 0 && n == e.poke + 1) begin
        chk("busy_start_busy", {63'd0, m_busy}, 64'd1);
        chk("busy_start_att", {62'd0, m_att}, {62'd0, e.poke_att});
      end
    end
    q = sb.pop_front();
    chk("done_cycle", 64'(n), 64'(q.cyc));
    chk("flags", {57'd0, m_done, m_busy, m_pass, m_idm, m_tsm, m_to, m_rd},
        {57'd0, 1'b1, 1'b0, q.pass, q.idm, q.tsm, q.to, 1'b0});
    chk("attempts", {62'd0, m_att}, {62'd0, q.att});
    chk("values", {m_idv, m_tsv}, {q.idv, q.tsv});
  endtask

  task automatic chk_zero(input string name);
    chk(name,
        {m_addr, m_rd, m_busy, m_done, m_pass, m_idm, m_tsm, m_to, m_att},
        64'd0);
    chk({name, "_vals"}, {m_idv, m_tsv}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    vec[0] = '{GID, GTS, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
               GID, GTS, 4, 0, 2'd0};
    vec[1] = '{32'd49154, GTS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3,
               32'd49154, GTS, 13, 0, 2'd0};
    vec[2] = '{GID, GTS, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1,
               GID, GTS, 7, 0, 2'd0};
    vec[3] = '{GID, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3,
               GID, 32'h1234_5678, 13, 0, 2'd0};

    repeat (3) @(negedge clk);
    sel = 1'b0;
    chk_zero("reset0");
    sel = 1'b1;
    chk_zero("reset2");
    reset = 1'b0;

    sel = 1'b0;
    for (int i = 0; i < 4; i++) run(vec[i]);

    e = vec[1];
    e.poke = 4;
    e.poke_att = 2'd1;
    run(e);

    sel = 1'b1;
    s_stall = 1'b1;
    e = vec[0];
    e.cyc = 18;
    run(e);
    s_stall = 1'b0;

    @(negedge clk);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, m_busy, m_idv}, {31'd0, 1'b1, GID});
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    sel = 1'b0;
    chk_zero("async_reset0");
    sel = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e = vec[0];
    e.cyc = 8;
    run(e);

`ifdef SYSID_CHECK_TIMEOUT_EN
    sel = 1'b0;
    s_stuck = 1'b1;
    e = vec[0];
    e.cyc = 17;
    e.pass = 1'b0;
    e.to = 1'b1;
    e.idv = 32'd0;
    e.tsv = 32'd0;
    run(e);
    s_stuck = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
